// File: rtl/boss_damage_controller.sv
// rtl/boss_damage_controller.sv - boss hit-point tracking, hit flash and death explosion sequencer
module boss_damage_controller #(
  parameter int BOSS_HP        = 8,
  parameter int FLASH_FRAMES   = 4,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       boss_fight,
  input  logic       enemy_hit,
  input  logic       frame_tick,
  output logic       done,
  output logic       laser_clear,
  output logic [3:0] boss_hp,
  output logic       boss_flash,
  output logic       boss_exploding,
  output logic [3:0] explode_frame,
  output logic       boss_defeated
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_HIT_ACK  = 3'd2;
  localparam logic [2:0] S_FLASH    = 3'd3;
  localparam logic [2:0] S_EXPLODE  = 3'd4;
  localparam logic [2:0] S_DEFEATED = 3'd5;

  localparam logic [3:0] HP_INIT    = 4'(BOSS_HP);
  localparam logic [4:0] FLASH_LAST = 5'(FLASH_FRAMES);
  localparam logic [3:0] EXPL_LAST  = 4'(EXPLODE_FRAMES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] hp_q, hp_d;
  logic [4:0] flash_cnt_q, flash_cnt_d;
  logic [3:0] expl_cnt_q, expl_cnt_d;
  logic       done_q, laser_clear_q, flash_q, exploding_q, defeated_q;

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    flash_cnt_d = flash_cnt_q;
    expl_cnt_d  = expl_cnt_q;
    if (!boss_fight) begin
      // Abort outranks every other transition, including a pending hit.
      state_d     = S_IDLE;
      hp_d        = HP_INIT;
      flash_cnt_d = 5'd0;
      expl_cnt_d  = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hp_d        = HP_INIT;
          flash_cnt_d = 5'd0;
          expl_cnt_d  = 4'd0;
          state_d     = S_ARMED;
        end
        S_ARMED: begin
          // A tick in the same cycle as a hit is simply dropped.
          if (enemy_hit && hp_q != 4'd0) begin
            hp_d    = hp_q - 4'd1;
            state_d = S_HIT_ACK;
          end
        end
        S_HIT_ACK: begin
          flash_cnt_d = 5'd0;
          expl_cnt_d  = 4'd0;
          state_d     = (hp_q == 4'd0) ? S_EXPLODE : S_FLASH;
        end
        S_FLASH: begin
          if (frame_tick) begin
            if (flash_cnt_q + 5'd1 >= FLASH_LAST) begin
              flash_cnt_d = 5'd0;
              state_d     = S_ARMED;
            end else begin
              flash_cnt_d = flash_cnt_q + 5'd1;
            end
          end
        end
        S_EXPLODE: begin
          if (frame_tick) begin
            if (expl_cnt_q == EXPL_LAST) begin
              state_d = S_DEFEATED;
            end else begin
              expl_cnt_d = expl_cnt_q + 4'd1;
            end
          end
        end
        S_DEFEATED: begin
          hp_d = 4'd0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= S_IDLE;
      hp_q          <= HP_INIT;
      flash_cnt_q   <= 5'd0;
      expl_cnt_q    <= 4'd0;
      done_q        <= 1'b0;
      laser_clear_q <= 1'b0;
      flash_q       <= 1'b0;
      exploding_q   <= 1'b0;
      defeated_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hp_q          <= hp_d;
      flash_cnt_q   <= flash_cnt_d;
      expl_cnt_q    <= expl_cnt_d;
      // Flags are registered from the next state so they line up with it.
      done_q        <= (state_d != S_ARMED);
      laser_clear_q <= (state_d == S_HIT_ACK);
      flash_q       <= (state_d == S_FLASH);
      exploding_q   <= (state_d == S_EXPLODE);
      defeated_q    <= (state_d == S_DEFEATED);
    end
  end

  assign done           = done_q;
  assign laser_clear    = laser_clear_q;
  assign boss_hp        = hp_q;
  assign boss_flash     = flash_q;
  assign boss_exploding = exploding_q;
  assign explode_frame  = expl_cnt_q;
  assign boss_defeated  = defeated_q;

endmodule

// File: tb/tb_boss_damage_controller.sv
// tb/tb_boss_damage_controller.sv - directed self-checking bench for boss_damage_controller
module tb_boss_damage_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       boss_fight = 1'b0;
  logic       enemy_hit = 1'b0;
  logic       frame_tick = 1'b0;
  logic       done, laser_clear, boss_flash, boss_exploding, boss_defeated;
  logic [3:0] boss_hp, explode_frame;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  boss_damage_controller dut (
    .Clk(Clk), .Reset(Reset), .boss_fight(boss_fight), .enemy_hit(enemy_hit),
    .frame_tick(frame_tick), .done(done), .laser_clear(laser_clear), .boss_hp(boss_hp),
    .boss_flash(boss_flash), .boss_exploding(boss_exploding),
    .explode_frame(explode_frame), .boss_defeated(boss_defeated)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic restart();
    boss_fight = 1'b0;
    enemy_hit  = 1'b0;
    frame_tick = 1'b0;
    step();
    boss_fight = 1'b1;
    step();
  endtask

  task automatic single_hit_and_flash();
    enemy_hit = 1'b1;
    step();
    enemy_hit = 1'b0;
    step();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset();
    restart();
    enemy_hit = 1'b1;
    step();
    enemy_hit = 1'b0;
    step();
    tick();
    #2 Reset = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0 || boss_flash !== 1'b0 || boss_hp !== 4'd8 || laser_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: done=%b flash=%b hp=%0d lc=%b, want 0 0 8 0", done, boss_flash, boss_hp, laser_clear);
    end
    boss_fight = 1'b0;
    step();
    Reset = 1'b1;
    step();
    n_checks++;
    if (done !== 1'b1 || boss_hp !== 4'd8) begin
      n_fail++;
      $display("FAIL reset_idle: done=%b hp=%0d, want 1 8", done, boss_hp);
    end
    boss_fight = 1'b1;
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_armed: done=%b, want 0", done);
    end
  endtask

  task automatic test_single_hit();
    restart();
    enemy_hit = 1'b1;
    step();
    enemy_hit = 1'b0;
    n_checks++;
    if (done !== 1'b1 || laser_clear !== 1'b1 || boss_hp !== 4'd7 || boss_flash !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_ack: done=%b lc=%b hp=%0d flash=%b, want 1 1 7 0", done, laser_clear, boss_hp, boss_flash);
    end
    step();
    n_checks++;
    if (boss_flash !== 1'b1 || laser_clear !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL flash_entry: flash=%b lc=%b done=%b, want 1 0 1", boss_flash, laser_clear, done);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (boss_flash !== 1'b1) begin
        n_fail++;
        $display("FAIL flash_hold tick %0d: flash=%b, want 1", i, boss_flash);
      end
    end
    tick();
    n_checks++;
    if (boss_flash !== 1'b0 || done !== 1'b0 || boss_hp !== 4'd7) begin
      n_fail++;
      $display("FAIL flash_exit: flash=%b done=%b hp=%0d, want 0 0 7", boss_flash, done, boss_hp);
    end
  endtask

  task automatic test_held_hit();
    restart();
    enemy_hit = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (boss_hp !== 4'd7 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_hit_flash: hp=%0d done=%b, want 7 0", boss_hp, done);
    end
    step();
    enemy_hit = 1'b0;
    n_checks++;
    if (boss_hp !== 4'd6 || laser_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL held_hit_second: hp=%0d lc=%b, want 6 1", boss_hp, laser_clear);
    end
    step();
    for (int i = 0; i < 4; i++) tick();
    step();
    n_checks++;
    if (boss_hp !== 4'd6 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL held_hit_final: hp=%0d done=%b, want 6 0", boss_hp, done);
    end
  endtask

  task automatic kill_boss();
    for (int h = 0; h < 7; h++) single_hit_and_flash();
    enemy_hit = 1'b1;
    step();
    enemy_hit = 1'b0;
    step();
  endtask

  task automatic test_kill();
    restart();
    kill_boss();
    n_checks++;
    if (boss_hp !== 4'd0 || boss_exploding !== 1'b1 || explode_frame !== 4'd0 || boss_flash !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_explode: hp=%0d expl=%b frame=%0d flash=%b, want 0 1 0 0", boss_hp, boss_exploding, explode_frame, boss_flash);
    end
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_checks++;
      if (explode_frame !== 4'(k) || boss_exploding !== 1'b1 || boss_defeated !== 1'b0) begin
        n_fail++;
        $display("FAIL explode_step %0d: frame=%0d expl=%b def=%b", k, explode_frame, boss_exploding, boss_defeated);
      end
    end
    tick();
    n_checks++;
    if (boss_defeated !== 1'b1 || boss_exploding !== 1'b0 || explode_frame !== 4'd15 || boss_hp !== 4'd0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL defeated: def=%b expl=%b frame=%0d hp=%0d done=%b, want 1 0 15 0 1", boss_defeated, boss_exploding, explode_frame, boss_hp, done);
    end
    tick();
    tick();
    enemy_hit = 1'b1;
    step();
    enemy_hit = 1'b0;
    n_checks++;
    if (boss_defeated !== 1'b1 || explode_frame !== 4'd15 || boss_hp !== 4'd0) begin
      n_fail++;
      $display("FAIL defeated_hold: def=%b frame=%0d hp=%0d, want 1 15 0", boss_defeated, explode_frame, boss_hp);
    end
  endtask

  task automatic test_hit_and_tick();
    restart();
    enemy_hit  = 1'b1;
    frame_tick = 1'b1;
    step();
    enemy_hit = 1'b0;
    n_checks++;
    if (boss_hp !== 4'd7 || laser_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_tick_ack: hp=%0d lc=%b, want 7 1", boss_hp, laser_clear);
    end
    step();
    frame_tick = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    n_checks++;
    if (boss_flash !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_tick_flash3: flash=%b, want 1", boss_flash);
    end
    tick();
    n_checks++;
    if (boss_flash !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_tick_flash4: flash=%b done=%b, want 0 0", boss_flash, done);
    end
  endtask

  task automatic test_abort_explode();
    restart();
    kill_boss();
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (explode_frame !== 4'd5 || boss_exploding !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: frame=%0d expl=%b, want 5 1", explode_frame, boss_exploding);
    end
    boss_fight = 1'b0;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    n_checks++;
    if (boss_exploding !== 1'b0 || explode_frame !== 4'd0 || boss_hp !== 4'd8 || boss_defeated !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: expl=%b frame=%0d hp=%0d def=%b done=%b, want 0 0 8 0 1", boss_exploding, explode_frame, boss_hp, boss_defeated, done);
    end
  endtask

  task automatic test_abort_beats_hit();
    restart();
    boss_fight = 1'b0;
    enemy_hit  = 1'b1;
    step();
    enemy_hit = 1'b0;
    n_checks++;
    if (boss_hp !== 4'd8 || laser_clear !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_vs_hit: hp=%0d lc=%b done=%b, want 8 0 1", boss_hp, laser_clear, done);
    end
  endtask

  initial begin
    step();
    Reset = 1'b1;
    step();
    test_reset();
    test_single_hit();
    test_held_hit();
    test_kill();
    test_hit_and_tick();
    test_abort_explode();
    test_abort_beats_hit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
